// File: rtl/crypto_pkg.sv
// Shared constants and state encoding for the session-key XOR stream stage.
package crypto_pkg;

  localparam int BYTE_W        = 8;
  localparam int KEY_BYTES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CRYPT   = 2'd2
  } state_t;

endpackage

// File: rtl/key_stream_xor_key_store.sv
// Session key register file: one synchronous write port, one asynchronous read port.
module key_store
  import crypto_pkg::*;
#(
  parameter int N  = KEY_BYTES_DEF,
  parameter int AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem_q [N];
  logic [BYTE_W-1:0] mem_d [N];

  // Next contents: write the addressed byte when enabled.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // Key storage, cleared on reset so a partial key never survives.
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  // Asynchronous read of the byte currently used for encryption.
  always_comb rd_data = mem_q[rd_addr];

endmodule

// File: rtl/key_stream_xor.sv
// Collects a session key from the random generator, then XOR-encrypts a byte stream.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no key; waiting for key_load
// ST_COLLECT | rnd_start high, capturing one random byte per rnd_rdy pulse
// ST_CRYPT   | key ready; plaintext accepted, key bytes applied cyclically
module key_stream_xor
  import crypto_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF,
  parameter int DATA_W    = BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              key_load,
  input  logic [DATA_W-1:0] rnd_value,
  input  logic              rnd_rdy,
  output logic              rnd_start,
  output logic              key_rdy,
  input  logic [DATA_W-1:0] pt_data,
  input  logic              pt_valid,
  output logic              pt_ready,
  output logic [DATA_W-1:0] ct_data,
  output logic              ct_valid,
  input  logic              ct_ready
);

  localparam int IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_BYTES - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  key_cnt_q, key_cnt_d;
  logic [IDX_W-1:0]  key_idx_q, key_idx_d;
  logic              rnd_start_q, rnd_start_d;
  logic              key_rdy_q, key_rdy_d;
  logic              ct_valid_q, ct_valid_d;
  logic [DATA_W-1:0] ct_data_q, ct_data_d;

  logic              cap;
  logic              xfer;
  logic              pop;
  logic [DATA_W-1:0] key_byte;

  key_store #(
    .N  (KEY_BYTES),
    .AW (IDX_W)
  ) u_key_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cap),
    .wr_addr (key_cnt_q),
    .wr_data (rnd_value),
    .rd_addr (key_idx_q),
    .rd_data (key_byte)
  );

  // State register; frozen while ena is low.
  always_ff @(posedge clk) begin
    if (rst)      state_q <= ST_IDLE;
    else if (ena) state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (key_load) state_d = ST_COLLECT;
      ST_COLLECT: if (cap && key_cnt_q == LAST_IDX) state_d = ST_CRYPT;
      ST_CRYPT:   if (key_load) state_d = ST_COLLECT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Handshake qualifiers; key_load blocks plaintext so a rekey never races a transfer.
  always_comb begin
    cap      = ena && state_q == ST_COLLECT && rnd_start_q && rnd_rdy;
    pt_ready = ena && state_q == ST_CRYPT && key_rdy_q && !key_load
               && (!ct_valid_q || ct_ready);
    xfer     = pt_valid && pt_ready;
    pop      = ena && ct_valid_q && ct_ready;
  end

  // Datapath next values: key counters, generator handshake and output register.
  always_comb begin
    rnd_start_d = rnd_start_q;
    key_rdy_d   = key_rdy_q;
    key_cnt_d   = key_cnt_q;
    key_idx_d   = key_idx_q;
    ct_valid_d  = ct_valid_q;
    ct_data_d   = ct_data_q;

    case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          rnd_start_d = 1'b1;
          key_cnt_d   = '0;
          key_idx_d   = '0;
        end
      end
      ST_COLLECT: begin
        if (cap) begin
          if (key_cnt_q == LAST_IDX) begin
            rnd_start_d = 1'b0;
            key_rdy_d   = 1'b1;
            key_cnt_d   = '0;
            key_idx_d   = '0;
          end else begin
            key_cnt_d = key_cnt_q + IDX_W'(1);
          end
        end
      end
      ST_CRYPT: begin
        if (key_load) begin
          rnd_start_d = 1'b1;
          key_rdy_d   = 1'b0;
          key_cnt_d   = '0;
          key_idx_d   = '0;
        end
      end
      default: ;
    endcase

    // A held byte is only replaced by a new transfer, so rekey never disturbs it.
    if (xfer) begin
      ct_data_d  = pt_data ^ key_byte;
      ct_valid_d = 1'b1;
      key_idx_d  = (key_idx_q == LAST_IDX) ? '0 : key_idx_q + IDX_W'(1);
    end else if (pop) begin
      ct_valid_d = 1'b0;
    end
  end

  // Datapath registers; frozen while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_start_q <= 1'b0;
      key_rdy_q   <= 1'b0;
      key_cnt_q   <= '0;
      key_idx_q   <= '0;
      ct_valid_q  <= 1'b0;
      ct_data_q   <= '0;
    end else if (ena) begin
      rnd_start_q <= rnd_start_d;
      key_rdy_q   <= key_rdy_d;
      key_cnt_q   <= key_cnt_d;
      key_idx_q   <= key_idx_d;
      ct_valid_q  <= ct_valid_d;
      ct_data_q   <= ct_data_d;
    end
  end

  assign rnd_start = rnd_start_q;
  assign key_rdy   = key_rdy_q;
  assign ct_valid  = ct_valid_q;
  assign ct_data   = ct_data_q;

endmodule

// File: tb/tb_key_stream_xor.sv
// Directed bench for key_stream_xor: key collection, streaming, backpressure, rekey, ena, reset.
module tb_key_stream_xor;

  logic       clk = 1'b0;
  logic       rst, ena, key_load, rnd_rdy, rnd_start, key_rdy;
  logic       pt_valid, pt_ready, ct_valid, ct_ready;
  logic [7:0] rnd_value, pt_data, ct_data;

  int pass_cnt = 0;
  int total    = 0;

  key_stream_xor #(.KEY_BYTES(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .key_load  (key_load),
    .rnd_value (rnd_value),
    .rnd_rdy   (rnd_rdy),
    .rnd_start (rnd_start),
    .key_rdy   (key_rdy),
    .pt_data   (pt_data),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .ct_data   (ct_data),
    .ct_valid  (ct_valid),
    .ct_ready  (ct_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Feed four random bytes with a gap between pulses; key_rdy must rise only after the fourth.
  task automatic collect_key(input logic [7:0] k0, k1, k2, k3, input int gap, input string tag);
    logic [7:0] k [4];
    k = '{k0, k1, k2, k3};
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) tick();
      rnd_value = k[i];
      rnd_rdy   = 1'b1;
      tick();
      rnd_rdy   = 1'b0;
      if (i == 2) begin
        chk({tag, "_rdy_after3"},   {7'd0, key_rdy},   8'd0);
        chk({tag, "_start_after3"}, {7'd0, rnd_start}, 8'd1);
      end
    end
    chk({tag, "_rdy_after4"},   {7'd0, key_rdy},   8'd1);
    chk({tag, "_start_after4"}, {7'd0, rnd_start}, 8'd0);
  endtask

  // Offer one plaintext byte with downstream ready and check the registered ciphertext.
  task automatic send(input logic [7:0] pt, input logic [7:0] exp, input string tag);
    pt_valid = 1'b1;
    pt_data  = pt;
    #1;
    chk({tag, "_pt_ready"}, {7'd0, pt_ready}, 8'd1);
    tick();
    chk({tag, "_ct_data"},  ct_data,           exp);
    chk({tag, "_ct_valid"}, {7'd0, ct_valid},  8'd1);
  endtask

  task automatic load_key();
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; key_load = 1'b0; rnd_rdy = 1'b0; rnd_value = 8'h00;
    pt_valid = 1'b0; pt_data = 8'h00; ct_ready = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_rnd_start", {7'd0, rnd_start}, 8'd0);
    chk("rst_key_rdy",   {7'd0, key_rdy},   8'd0);
    chk("rst_ct_valid",  {7'd0, ct_valid},  8'd0);
    chk("rst_ct_data",   ct_data,           8'h00);
    chk("rst_pt_ready",  {7'd0, pt_ready},  8'd0);
    rst = 1'b0;

    // rnd_rdy before key_load is ignored
    rnd_value = 8'h99; rnd_rdy = 1'b1;
    tick();
    rnd_rdy = 1'b0;
    chk("idle_rnd_start", {7'd0, rnd_start}, 8'd0);
    chk("idle_key_rdy",   {7'd0, key_rdy},   8'd0);

    // Key collect
    load_key();
    chk("collect_start", {7'd0, rnd_start}, 8'd1);
    key_load = 1'b1;                       // ignored during COLLECT
    tick();
    key_load = 1'b0;
    collect_key(8'h11, 8'h22, 8'h33, 8'h44, 9, "key1");

    // Stream with wrap, one byte per cycle
    ct_ready = 1'b1;
    send(8'hAA, 8'hBB, "s0");
    send(8'h55, 8'h77, "s1");
    send(8'h00, 8'h33, "s2");
    send(8'hFF, 8'hBB, "s3");
    send(8'hAA, 8'hBB, "s4_wrap");
    pt_valid = 1'b0;
    tick();
    chk("s_drain_valid", {7'd0, ct_valid}, 8'd0);

    // Backpressure (key_idx now 1)
    ct_ready = 1'b0;
    send(8'h5A, 8'h78, "bp0");
    pt_data = 8'h6B;
    #1;
    chk("bp_pt_ready_low", {7'd0, pt_ready}, 8'd0);
    tick();
    chk("bp_hold1", ct_data, 8'h78);
    tick();
    chk("bp_hold2", ct_data, 8'h78);
    chk("bp_hold_valid", {7'd0, ct_valid}, 8'd1);
    ct_ready = 1'b1;
    send(8'h6B, 8'h58, "bp1");
    pt_valid = 1'b0;
    tick();
    chk("bp_drain_valid", {7'd0, ct_valid}, 8'd0);

    // Rekey with a held ciphertext byte (key_idx now 3)
    ct_ready = 1'b0;
    send(8'h0F, 8'h4B, "rk_held");
    key_load = 1'b1;
    #1;
    chk("rk_pt_blocked", {7'd0, pt_ready}, 8'd0);
    tick();
    key_load = 1'b0;
    pt_valid = 1'b0;
    chk("rk_key_rdy", {7'd0, key_rdy},   8'd0);
    chk("rk_start",   {7'd0, rnd_start}, 8'd1);
    chk("rk_hold_data",  ct_data,           8'h4B);
    chk("rk_hold_valid", {7'd0, ct_valid},  8'd1);
    collect_key(8'h01, 8'h02, 8'h03, 8'h04, 2, "key2");
    chk("rk_hold_data2", ct_data, 8'h4B);
    ct_ready = 1'b1;
    tick();
    chk("rk_popped", {7'd0, ct_valid}, 8'd0);
    send(8'h10, 8'h11, "rk_new");
    pt_valid = 1'b0;
    tick();

    // ena gating during COLLECT
    load_key();
    ena = 1'b0; rnd_value = 8'hEE; rnd_rdy = 1'b1;
    tick(); tick();
    rnd_rdy = 1'b0; ena = 1'b1;
    chk("ena_start_frozen", {7'd0, rnd_start}, 8'd1);
    collect_key(8'hA0, 8'hB0, 8'hC0, 8'hD0, 1, "key3");

    // ena gating in CRYPT
    ena = 1'b0; pt_valid = 1'b1; pt_data = 8'h00; ct_ready = 1'b1;
    #1;
    chk("ena_pt_ready", {7'd0, pt_ready}, 8'd0);
    tick();
    chk("ena_no_xfer", {7'd0, ct_valid}, 8'd0);
    ena = 1'b1;
    ct_ready = 1'b0;
    send(8'h00, 8'hA0, "ena_key_idx0");

    // Reset mid-CRYPT with a held byte
    pt_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ct_valid",  {7'd0, ct_valid},  8'd0);
    chk("mrst_ct_data",   ct_data,           8'h00);
    chk("mrst_key_rdy",   {7'd0, key_rdy},   8'd0);
    chk("mrst_rnd_start", {7'd0, rnd_start}, 8'd0);

    // Reset mid-COLLECT, then a full fresh collection from key_cnt 0
    load_key();
    rnd_value = 8'h77; rnd_rdy = 1'b1; tick();
    rnd_value = 8'h66; tick();
    rnd_rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("crst_rnd_start", {7'd0, rnd_start}, 8'd0);
    load_key();
    collect_key(8'h10, 8'h20, 8'h30, 8'h40, 1, "key4");
    ct_ready = 1'b1;
    send(8'h01, 8'h11, "k4_b0");
    send(8'h02, 8'h22, "k4_b1");
    send(8'h03, 8'h33, "k4_b2");
    send(8'h04, 8'h44, "k4_b3");
    pt_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
